// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared constants, state type and lane helper for the SHA-2 padder
package sha2_pkg;

  // Bit positions inside the one-hot mode {512_256, 512, 384, 256}
  localparam int MODE_256     = 0;
  localparam int MODE_384     = 1;
  localparam int MODE_512     = 2;
  localparam int MODE_512_256 = 3;

  localparam int         BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {IDLE, FILL, LOAD, RUN, DONE} state_t;

  // One byte lane: keep message bytes, place the marker right after them, zero the rest
  function automatic logic [7:0] pad_lane(input logic [7:0] d, input logic [3:0] lane,
                                          input logic [3:0] nbytes, input logic marker);
    if (lane < nbytes) return d;
    else if (marker && lane == nbytes) return PAD_BYTE;
    else return 8'h00;
  endfunction

endpackage

// File: rtl/sha2_pad_word.sv
// rtl/sha2_pad_word.sv - byte masking and 0x80 marker insertion for one message word
module sha2_pad_word
  import sha2_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  input  logic        wide,
  input  logic        marker,
  output logic [63:0] word
);

  logic [63:0] wide_w;
  logic [63:0] narrow_w;

  for (genvar i = 0; i < 8; i++) begin : g_wide
    assign wide_w[63-8*i -: 8] = pad_lane(data[63-8*i -: 8], 4'(i), nbytes, marker);
  end

  // 4-byte words live in [31:0]; the upper half stays zero
  for (genvar i = 0; i < 4; i++) begin : g_narrow
    assign narrow_w[31-8*i -: 8] = pad_lane(data[31-8*i -: 8], 4'(i), nbytes, marker);
  end
  assign narrow_w[63:32] = '0;

  assign word = wide ? wide_w : narrow_w;

endmodule

// File: rtl/sha2_padder.sv
// rtl/sha2_padder.sv - buffers/pads message blocks and sequences sha2_core load/start
// Optional input checking with sticky err when SHA2_PADDER_ERR_EN is defined.
module sha2_padder
  import sha2_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        core_load,
  output logic        core_start,
  output logic [63:0] core_data,
  input  logic        core_end_op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t           state, state_nx;
  logic [63:0]      blk_buf [BLOCK_WORDS];
  logic [3:0]       wcnt;
  logic [LEN_W-1:0] bitlen;
  logic [LEN_W-1:0] add_bits;
  logic [63:0]      len64;
  logic             wide, last_seen, pad_pend, len_pend, len_blk;
  logic [3:0]       wb;
  logic             accept, gen, wr, mark_now;
  logic [63:0]      pw_data, pw_word, wr_word;
  logic [3:0]       pw_bytes;
  logic             pw_marker;

  assign wb       = wide ? 4'd8 : 4'd4;
  assign accept   = in_ready && in_valid;
  assign gen      = (state == FILL) && last_seen;
  assign wr       = accept || gen;
  assign add_bits = LEN_W'({in_bytes, 3'b000});
  assign len64    = 64'(bitlen);
  assign mark_now = (accept && in_last && in_bytes < wb) || (gen && pad_pend);

  // Generated words reuse the lane logic: an empty word with the marker in lane 0
  assign pw_data   = accept ? in_data  : '0;
  assign pw_bytes  = accept ? in_bytes : 4'd0;
  assign pw_marker = accept ? in_last  : pad_pend;

  sha2_pad_word u_pad_word (
    .data   (pw_data),
    .nbytes (pw_bytes),
    .wide   (wide),
    .marker (pw_marker),
    .word   (pw_word)
  );

  always_comb begin
    wr_word = pw_word;
    if (gen && !pad_pend && len_blk) begin
      if (wcnt == 4'd14) wr_word = wide ? 64'd0 : {32'd0, len64[63:32]};
      if (wcnt == 4'd15) wr_word = wide ? len64 : {32'd0, len64[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    core_load  = 1'b0;
    core_start = 1'b0;
    core_data  = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nx = FILL;
      FILL: begin
        in_ready = !last_seen;
        if (wr && wcnt == 4'd15) state_nx = LOAD;
      end
      LOAD: begin
        core_load = 1'b1;
        core_data = blk_buf[wcnt];
        if (wcnt == 4'd15) state_nx = RUN;
      end
      RUN: begin
        core_start = !core_end_op;
        if (core_end_op) state_nx = len_blk ? DONE : FILL;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) blk_buf[wcnt] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt      <= '0;
      bitlen    <= '0;
      wide      <= 1'b0;
      last_seen <= 1'b0;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      len_blk   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wcnt      <= '0;
          bitlen    <= '0;
          last_seen <= 1'b0;
          pad_pend  <= 1'b0;
          len_pend  <= 1'b0;
          len_blk   <= 1'b0;
          wide      <= (mode != (4'b0001 << MODE_256));
        end
        FILL: if (wr) begin
          wcnt <= wcnt + 4'd1;
          if (accept) begin
            bitlen <= bitlen + add_bits;
            if (in_last) begin
              last_seen <= 1'b1;
              if (in_bytes >= wb) pad_pend <= 1'b1;
            end
          end
          if (gen && pad_pend) pad_pend <= 1'b0;
          // Words 14/15 must stay free for the length, else it moves to an extra block
          if (mark_now) begin
            if (wcnt <= 4'd13) len_blk  <= 1'b1;
            else               len_pend <= 1'b1;
          end
        end
        LOAD: wcnt <= wcnt + 4'd1;
        RUN: if (core_end_op && len_pend) begin
          len_blk  <= 1'b1;
          len_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA2_PADDER_ERR_EN
  logic         err_q;
  logic [LEN_W:0] len_sum;

  assign len_sum = {1'b0, bitlen} + {1'b0, add_bits};

  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) err_q <= 1'b0;
    else if (accept && (in_bytes > wb || (in_bytes < wb && !in_last) || len_sum[LEN_W]))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha2_padder.sv
// tb/tb_sha2_padder.sv - randomized bench for sha2_padder with a simple sha2_core stand-in
module tb_sha2_padder;

  localparam logic [3:0] M256 = 4'b0001, M384 = 4'b0010, M512 = 4'b0100, M512_256 = 4'b1000;
`ifdef SHA2_PADDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  mode = M256;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [3:0]  in_bytes = '0;
  logic        core_load, core_start;
  logic [63:0] core_data;
  logic        core_end_op = 1'b0;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha2_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes), .core_load(core_load),
    .core_start(core_start), .core_data(core_data), .core_end_op(core_end_op),
    .busy(busy), .done(done), .err(err)
  );

  // sha2_core stand-in: captures loaded words, runs a round counter, holds end_op until next load
  logic [63:0] got[$];
  int core_rounds = 62;
  int rounds = 0;
  int load_run = 0;
  int burst_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      core_end_op = 1'b0;
      rounds = 0;
      load_run = 0;
    end else begin
      if (core_load) begin
        got.push_back(core_data);
        core_end_op = 1'b0;
        rounds = 0;
        load_run++;
        n_checks++;
        if (core_start !== 1'b0) begin
          n_fail++;
          $display("FAIL start_in_load: core_start=%b required 0", core_start);
        end
      end else if (load_run != 0) begin
        n_checks++;
        if (load_run != 16) begin
          n_fail++;
          $display("FAIL load_burst: %0d contiguous load cycles, required 16", load_run);
        end
        burst_cnt++;
        load_run = 0;
      end
      if (core_start && !core_end_op) begin
        rounds++;
        if (rounds >= core_rounds) core_end_op = 1'b1;
      end
      if (done) done_cnt++;
    end
  end

  // Reference: FIPS 180-4 padding of the whole byte string, then split into words
  function automatic void model(input logic [3:0] m, input byte unsigned msg[$],
                                output logic [63:0] words[$]);
    byte unsigned p[$];
    int wb, bb, lb;
    longint unsigned bits;
    logic [63:0] w;
    wb = (m == M256) ? 4 : 8;
    bb = (m == M256) ? 64 : 128;
    lb = (m == M256) ? 8 : 16;
    bits = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % bb) != bb - lb) p.push_back(8'h00);
    for (int i = lb - 1; i >= 0; i--) p.push_back((i < 8) ? 8'(bits >> (8 * i)) : 8'h00);
    words.delete();
    for (int i = 0; i < p.size(); i += wb) begin
      w = '0;
      for (int j = 0; j < wb; j++) w = (w << 8) | 64'(p[i + j]);
      words.push_back(w);
    end
  endfunction

  function automatic void rand_msg(input int n, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  // Called and returns at posedge+1
  task automatic push_word(input logic [63:0] d, input logic [3:0] b, input logic l);
    bit fire = 1'b0;
    int cyc = 0;
    in_valid = 1'b1; in_data = d; in_bytes = b; in_last = l;
    while (!fire && cyc < 2000) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!fire) begin
      n_checks++; n_fail++;
      $display("FAIL push_word_timeout: in_ready low for %0d cycles, required accept", cyc);
    end
  endtask

  task automatic send_msg(input logic [3:0] m, input byte unsigned msg[$], input bit stall);
    int wb, n, nwords, nb, pos;
    logic [63:0] d;
    wb = (m == M256) ? 4 : 8;
    n = msg.size();
    nwords = (n == 0) ? 1 : (n + wb - 1) / wb;
    mode = m;
    for (int w = 0; w < nwords; w++) begin
      if (stall) begin in_valid = 1'b0; @(posedge clk); #1; end
      d = {$urandom, $urandom};
      nb = n - w * wb;
      if (nb > wb) nb = wb;
      for (int j = 0; j < nb; j++) begin
        pos = (wb - 1 - j) * 8;
        d = (d & ~(64'hFF << pos)) | (64'(msg[w * wb + j]) << pos);
      end
      push_word(d, 4'(nb), w == nwords - 1);
    end
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin @(posedge clk); #1; cyc++; end
    if (done_cnt == 0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, required 1 pulse", budget);
    end
  endtask

  task automatic run_and_check(input string name, input logic [3:0] m,
                               input byte unsigned msg[$], input bit stall);
    logic [63:0] exp[$];
    got.delete(); done_cnt = 0; burst_cnt = 0;
    core_rounds = (m == M256) ? 62 : 78;
    send_msg(m, msg, stall);
    wait_done(4000);
    @(negedge clk);
    model(m, msg, exp);
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done_count: %0d required 1", name, done_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: %b required 0", name, busy); end
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++; $display("FAIL %s word_count: %0d required %0d", name, got.size(), exp.size());
    end
    n_checks++;
    if (burst_cnt != exp.size() / 16) begin
      n_fail++; $display("FAIL %s bursts: %0d required %0d", name, burst_cnt, exp.size() / 16);
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL %s word%0d: %h required %h", name, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: %b required 0", in_ready); end
    n_checks++; if (core_load !== 1'b0) begin n_fail++; $display("FAIL rst_core_load: %b required 0", core_load); end
    n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_core_start: %b required 0", core_start); end
    n_checks++; if (core_data !== 64'd0) begin n_fail++; $display("FAIL rst_core_data: %h required 0", core_data); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: %b required 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: %b required 0", done); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    byte unsigned msg[$];
    msg = '{8'h61, 8'h62, 8'h63};
    run_and_check("abc", M256, msg, 1'b0);
    n_checks++;
    if (got.size() < 1 || got[0] !== 64'h61626380) begin n_fail++; $display("FAIL abc_w0: %h required 61626380", got[0]); end
    n_checks++;
    if (got.size() < 16 || got[15] !== 64'h18) begin n_fail++; $display("FAIL abc_w15: %h required 18", got[15]); end
  endtask

  task automatic test_empty_512();
    byte unsigned msg[$];
    msg.delete();
    run_and_check("empty512", M512, msg, 1'b0);
    n_checks++;
    if (got.size() < 1 || got[0] !== 64'h8000000000000000) begin
      n_fail++; $display("FAIL empty512_w0: %h required 8000000000000000", got[0]);
    end
  endtask

  task automatic test_two_block();
    byte unsigned msg[$];
    rand_msg(56, msg);
    run_and_check("len56", M256, msg, 1'b0);
    n_checks++;
    if (burst_cnt != 2) begin n_fail++; $display("FAIL len56_bursts: %0d required 2", burst_cnt); end
    n_checks++;
    if (got.size() < 32 || got[31] !== 64'h1c0) begin n_fail++; $display("FAIL len56_w31: %h required 1c0", got[31]); end
  endtask

  task automatic test_boundaries();
    byte unsigned msg[$];
    int lens256[5] = '{55, 63, 64, 119, 120};
    int lens512[4] = '{111, 112, 127, 128};
    foreach (lens256[i]) begin rand_msg(lens256[i], msg); run_and_check($sformatf("b256_%0d", lens256[i]), M256, msg, 1'b0); end
    foreach (lens512[i]) begin rand_msg(lens512[i], msg); run_and_check($sformatf("b384_%0d", lens512[i]), M384, msg, 1'b0); end
  endtask

  task automatic test_backpressure();
    byte unsigned msg[$];
    logic [63:0] first[$];
    rand_msg(100, msg);
    run_and_check("nostall", M512, msg, 1'b0);
    first = got;
    run_and_check("stall", M512, msg, 1'b1);
    n_checks++;
    if (first != got) begin n_fail++; $display("FAIL stall_vs_nostall: %0d words differ from %0d-word no-stall run", got.size(), first.size()); end
  endtask

  task automatic test_random();
    byte unsigned msg[$];
    logic [3:0] m;
    for (int k = 0; k < 8; k++) begin
      m = 4'b0001 << $urandom_range(0, 3);
      rand_msg($urandom_range(0, 260), msg);
      run_and_check($sformatf("rand%0d_m%h_n%0d", k, m, msg.size()), m, msg, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_run();
    byte unsigned msg[$];
    int cyc = 0;
    rand_msg(20, msg);
    got.delete(); done_cnt = 0; core_rounds = 62;
    send_msg(M256, msg, 1'b0);
    while (!core_start && cyc < 500) begin @(negedge clk); cyc++; end
    n_checks++;
    if (!core_start) begin n_fail++; $display("FAIL midrun_reach_run: core_start=%b required 1", core_start); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, core_load, core_start, busy, done} !== 5'b0 || core_data !== 64'd0) begin
      n_fail++;
      $display("FAIL midrun_outputs: rdy=%b load=%b start=%b busy=%b done=%b data=%h required all 0",
               in_ready, core_load, core_start, busy, done, core_data);
    end
    @(posedge clk); #1;
    test_abc();
  endtask

  task automatic test_err();
    bit exp_err;
    got.delete(); done_cnt = 0; core_rounds = 62;
    exp_err = ERR_EN;
    mode = M256;
    push_word(64'h61626300, 4'd3, 1'b0);
    @(negedge clk);
    n_checks++;
    if (err !== exp_err) begin n_fail++; $display("FAIL err_set: %b required %b", err, exp_err); end
    @(posedge clk); #1;
    push_word(64'h64656667, 4'd4, 1'b1);
    wait_done(4000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_idle_clear: %b required 0", err); end
    n_checks++;
    if (got.size() != 16) begin n_fail++; $display("FAIL err_processed: %0d words required 16", got.size()); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty_512();
    test_two_block();
    test_boundaries();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
